// File: rtl/acumulador_suma_if.sv
// Handshake bundle between the selective-adder feed, the accumulator and its consumer.
// The producer/consumer side uses the master modport. The accumulator uses the slave modport.
interface acumulador_suma_if #(
    parameter int NB_IN      = 4,
    parameter int NB_ACC     = 8,
    parameter int N_MUESTRAS = 4
);
    localparam int NB_CNT = $clog2(N_MUESTRAS + 1);

    logic              i_valid;
    logic [NB_IN-1:0]  i_data;
    logic              i_clear;
    logic              i_ack;
    logic              o_ready;
    logic [NB_ACC-1:0] o_acc;
    logic              o_valid;
    logic              o_overflow;
    logic [NB_CNT-1:0] o_count;

    modport master (
        output i_valid, i_data, i_clear, i_ack,
        input  o_ready, o_acc, o_valid, o_overflow, o_count
    );

    modport slave (
        input  i_valid, i_data, i_clear, i_ack,
        output o_ready, o_acc, o_valid, o_overflow, o_count
    );
endinterface

// File: rtl/acumulador_suma.sv
// Saturating block accumulator: sums N_MUESTRAS accepted samples and holds the
// result with o_valid until the consumer acknowledges it.
module acumulador_suma #(
    parameter int NB_IN      = 4,
    parameter int NB_ACC     = 8,
    parameter int N_MUESTRAS = 4
) (
    input  logic              clock,
    input  logic              i_reset,
    acumulador_suma_if.slave  bus
);
    localparam int NB_CNT = $clog2(N_MUESTRAS + 1);

    typedef enum logic {
        ACUM = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NB_ACC-1:0] acc_q,   acc_d;
    logic [NB_CNT-1:0] count_q, count_d;
    logic              ovf_q,   ovf_d;
    logic [NB_ACC:0]   sum;

    assign sum = {1'b0, acc_q} + {{(NB_ACC + 1 - NB_IN){1'b0}}, bus.i_data};

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so no
        // path through the case below can leave one unassigned and infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ACUM: begin
                if (bus.i_valid) begin
                    if (sum[NB_ACC]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[NB_ACC-1:0];
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == NB_CNT'(N_MUESTRAS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.i_ack) begin
                    state_d = ACUM;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACUM;
        endcase

        // Clear overrides normal operation, in either state.
        if (bus.i_clear) begin
            state_d = ACUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (i_reset) begin
            state_q <= ACUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.o_ready    = (state_q == ACUM);
    assign bus.o_valid    = (state_q == DONE);
    assign bus.o_acc      = acc_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_count    = count_q;
endmodule

// File: tb/tb_acumulador_suma.sv
// Bench for acumulador_suma: a default instance (NB_ACC=8) and a narrow one (NB_ACC=5)
// share the stimulus; an integer model predicts both, and directed expectations pin it.
module tb_acumulador_suma;
    logic clock = 1'b0;
    logic i_reset;
    logic v, c, a;
    logic [3:0] d;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    acumulador_suma_if #(.NB_IN(4), .NB_ACC(8), .N_MUESTRAS(4)) if_a ();
    acumulador_suma_if #(.NB_IN(4), .NB_ACC(5), .N_MUESTRAS(4)) if_b ();

    assign if_a.i_valid = v;
    assign if_a.i_data  = d;
    assign if_a.i_clear = c;
    assign if_a.i_ack   = a;
    assign if_b.i_valid = v;
    assign if_b.i_data  = d;
    assign if_b.i_clear = c;
    assign if_b.i_ack   = a;

    acumulador_suma #(.NB_IN(4), .NB_ACC(8), .N_MUESTRAS(4)) u_a (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (if_a)
    );

    acumulador_suma #(.NB_IN(4), .NB_ACC(5), .N_MUESTRAS(4)) u_b (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (if_b)
    );

    typedef struct {
        int acc;
        int cnt;
        bit ov;
        bit done;
    } mdl_t;

    mdl_t m_a = '{0, 0, 1'b0, 1'b0};
    mdl_t m_b = '{0, 0, 1'b0, 1'b0};
    bit   armed = 1'b0;

    function automatic mdl_t step(mdl_t m, bit rst, bit clr, bit vld, int din, bit ack,
                                  int nacc, int n);
        mdl_t r;
        int   top;
        r   = m;
        top = (1 << nacc) - 1;
        if (rst || clr) begin
            r = '{0, 0, 1'b0, 1'b0};
        end else if (!m.done) begin
            if (vld) begin
                if (m.acc + din > top) begin
                    r.acc = top;
                    r.ov  = 1'b1;
                end else begin
                    r.acc = m.acc + din;
                end
                r.cnt  = m.cnt + 1;
                r.done = (r.cnt == n);
            end
        end else if (ack) begin
            r = '{0, 0, 1'b0, 1'b0};
        end
        return r;
    endfunction

    always @(posedge clock) begin
        m_a <= step(m_a, i_reset, c, v, int'(d), a, 8, 4);
        m_b <= step(m_b, i_reset, c, v, int'(d), a, 5, 4);
        if (i_reset) armed <= 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (armed) begin
            check("a.acc",   int'(if_a.o_acc),      m_a.acc);
            check("a.count", int'(if_a.o_count),    m_a.cnt);
            check("a.ovf",   int'(if_a.o_overflow), int'(m_a.ov));
            check("a.valid", int'(if_a.o_valid),    int'(m_a.done));
            check("a.ready", int'(if_a.o_ready),    int'(!m_a.done));
            check("b.acc",   int'(if_b.o_acc),      m_b.acc);
            check("b.count", int'(if_b.o_count),    m_b.cnt);
            check("b.ovf",   int'(if_b.o_overflow), int'(m_b.ov));
            check("b.valid", int'(if_b.o_valid),    int'(m_b.done));
            check("b.ready", int'(if_b.o_ready),    int'(!m_b.done));
        end
    end

    // One clock: set inputs, let the edge happen, return 1 time unit after it.
    task automatic cyc(input bit rst, input bit vld, input int din, input bit clr,
                       input bit ack);
        i_reset = rst;
        v       = vld;
        d       = 4'(din);
        c       = clr;
        a       = ack;
        @(posedge clock);
        #1;
    endtask

    task automatic sample(input int din);
        cyc(1'b0, 1'b1, din, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic ack_cycle();
        cyc(1'b0, 1'b1, 9, 1'b0, 1'b1);
    endtask

    int pulses;

    initial begin
        // Reset with a live sample on the bus.
        cyc(1'b1, 1'b1, 9, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 9, 1'b0, 1'b0);
        i_reset = 1'b0;
        v       = 1'b0;
        check("rst.acc",   int'(if_a.o_acc), 0);
        check("rst.count", int'(if_a.o_count), 0);
        check("rst.valid", int'(if_a.o_valid), 0);
        check("rst.ovf",   int'(if_a.o_overflow), 0);
        check("rst.ready", int'(if_a.o_ready), 1);

        // Basic block.
        sample(3);  check("basic.acc1", int'(if_a.o_acc), 3);
        sample(5);  check("basic.acc2", int'(if_a.o_acc), 8);
        sample(7);  check("basic.acc3", int'(if_a.o_acc), 15);
        sample(15); check("basic.acc4", int'(if_a.o_acc), 30);
        check("basic.valid", int'(if_a.o_valid), 1);
        check("basic.ready", int'(if_a.o_ready), 0);
        check("basic.count", int'(if_a.o_count), 4);
        for (int i = 0; i < 5; i++) begin
            sample(9);
            check("basic.hold", int'(if_a.o_acc), 30);
        end
        ack_cycle();
        check("basic.ack_acc",   int'(if_a.o_acc), 0);
        check("basic.ack_ready", int'(if_a.o_ready), 1);
        check("basic.ack_count", int'(if_a.o_count), 0);

        // Gaps between samples.
        sample(2); idle(); idle(); sample(4); idle(); sample(6);
        check("gaps.not_yet", int'(if_a.o_valid), 0);
        sample(8);
        check("gaps.valid", int'(if_a.o_valid), 1);
        check("gaps.acc",   int'(if_a.o_acc), 20);
        check("gaps.count", int'(if_a.o_count), 4);
        ack_cycle();

        // Saturation on the narrow instance; the wide one just sums.
        sample(15); check("sat.b1", int'(if_b.o_acc), 15);
        check("sat.ovf0", int'(if_b.o_overflow), 0);
        sample(15); check("sat.b2", int'(if_b.o_acc), 30);
        sample(15); check("sat.b3", int'(if_b.o_acc), 31);
        check("sat.ovf3", int'(if_b.o_overflow), 1);
        sample(1);  check("sat.b4", int'(if_b.o_acc), 31);
        check("sat.done_ovf", int'(if_b.o_overflow), 1);
        check("sat.valid", int'(if_b.o_valid), 1);
        check("sat.a4", int'(if_a.o_acc), 46);
        check("sat.a_ovf", int'(if_a.o_overflow), 0);
        ack_cycle();
        check("sat.ack_ovf", int'(if_b.o_overflow), 0);

        // Clear mid-block, then clear while holding a result.
        sample(4); sample(4);
        cyc(1'b0, 1'b1, 4, 1'b1, 1'b0);
        check("clr.acc",   int'(if_a.o_acc), 0);
        check("clr.count", int'(if_a.o_count), 0);
        for (int i = 0; i < 4; i++) sample(1);
        check("clr.acc4",  int'(if_a.o_acc), 4);
        check("clr.valid", int'(if_a.o_valid), 1);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        check("clr_done.valid", int'(if_a.o_valid), 0);
        check("clr_done.acc",   int'(if_a.o_acc), 0);
        idle();
        check("clr_done.no_pulse", int'(if_a.o_valid), 0);

        // Back-to-back blocks with ack tied high.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 2, 1'b0, 1'b1);
            if (if_a.o_valid) begin
                pulses++;
                check("b2b.acc", int'(if_a.o_acc), 8);
                check("b2b.phase", i % 5, 3);
            end
        end
        check("b2b.pulses", pulses, 4);

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/acumulador_suma.md
# acumulador_suma

Accumulator stage directly downstream of the selective adder. It takes the adder's 4-bit result, one sample per cycle when `i_valid` is high, and sums `N_MUESTRAS` accepted samples into a saturating register. It then holds the block result with `o_valid` until the consumer acknowledges it, and starts the next block. The valid/ready handshake lets it be fed from a registered copy of the adder output.

## Interface
- `NB_IN`, default 4: input sample width (matches the adder output).
- `NB_ACC`, default 8: accumulator width. Must be ≥ `NB_IN`.
- `N_MUESTRAS`, default 4: samples per block. Must be ≥ 1.
- `clock`  in  1: single clock, rising edge.
- `i_reset`  in  1: synchronous, active-high reset.
- `i_valid`  in  1: `i_data` is valid this cycle.
- `i_data`  in  `NB_IN`: unsigned sample from the selective adder.
- `i_clear`  in  1: synchronous abort of the current block.
- `i_ack`  in  1: consumer accepts the held result.
- `o_ready`  out  1: block accepts a sample this cycle.
- `o_acc`  out  `NB_ACC`: running sum in ACUM; final sum in DONE.
- `o_valid`  out  1: `o_acc` holds a completed block result.
- `o_overflow`  out  1: sticky saturation flag for the current block.
- `o_count`  out  `$clog2(N_MUESTRAS+1)`: samples accepted in the current block.

## Operation
- FSM has two states: ACUM and DONE. All outputs are registered or decoded from registered state only. No combinational path from `i_*` to `o_*`.
- Priority, highest first: `i_reset` > `i_clear` > normal operation.
- Reset and clear behave identically: state = ACUM, `o_acc` = 0, `o_count` = 0, `o_overflow` = 0, `o_valid` = 0. `o_ready` = 1 from the first cycle after release.
- **ACUM** (`o_ready` = 1, `o_valid` = 0):
  - A sample is accepted when `i_valid` = 1 on a rising edge.
  - On acceptance: sum = `{0, o_acc}` + zero-extended `i_data`, computed in `NB_ACC`+1 bits.
  - If the carry bit is 1: `o_acc` = all ones and `o_overflow` is set to 1. Otherwise `o_acc` = the low `NB_ACC` bits.
  - `o_count` increments on every accepted sample.
  - Cycles with `i_valid` = 0 change nothing.
  - When the accepted sample is the `N_MUESTRAS`-th (`o_count` was `N_MUESTRAS`-1), the next state is DONE and `o_count` = `N_MUESTRAS`.
- **DONE** (`o_ready` = 0, `o_valid` = 1):
  - `o_acc`, `o_overflow` and `o_count` are frozen.
  - `i_valid` and `i_data` are ignored; samples presented here are dropped, and the producer must respect `o_ready`.
  - On `i_ack` = 1: state = ACUM, with `o_acc`, `o_count` and `o_overflow` cleared.
- `i_ack` in ACUM is ignored.
- `i_clear` in DONE discards the held result, with no `o_valid` pulse afterwards.
- Once set, saturation persists for the rest of the block: further samples keep `o_acc` at all ones.

## Timing
- Latency: a sample accepted at edge k is reflected in `o_acc`/`o_count` after edge k.
- The final sample at edge k gives `o_valid` = 1 and `o_ready` = 0 after edge k.
- Throughput: one sample per cycle in ACUM.
- Minimum block period is `N_MUESTRAS` + 1 cycles when `i_ack` is tied high: `N_MUESTRAS` accepting cycles plus one DONE cycle.
- `i_ack` sampled at edge m in DONE gives `o_valid` = 0 and `o_ready` = 1 after edge m. A sample offered in the same cycle as `i_ack` is not accepted; the first acceptable sample is at edge m+1.
- With `N_MUESTRAS` = 1, every accepted sample goes directly to DONE.
- Reset or clear asserted mid-block takes effect at that edge. A sample presented in the same cycle is discarded.

## Test plan
- **Reset:** assert `i_reset` for 2 cycles with `i_valid` = 1, `i_data` = 9 -> after release `o_acc` = 0, `o_count` = 0, `o_valid` = 0, `o_overflow` = 0, `o_ready` = 1.
- **Basic block:** defaults; samples 3, 5, 7, 15 on consecutive cycles, `i_ack` = 0 -> `o_acc` steps 3, 8, 15, 30. `o_valid` = 1 after the 4th edge. `o_acc` = 30 is held for 5 cycles while extra `i_valid` samples are ignored. `i_ack` -> next cycle `o_acc` = 0, `o_ready` = 1.
- **Gaps:** samples 2, gap, gap, 4, gap, 6, 8 -> `o_valid` only after the 8 is accepted, `o_acc` = 20, `o_count` = 4.
- **Saturation:** `NB_ACC` = 5; samples 15, 15, 15, 1 -> `o_acc` = 15, 30, 31, 31. `o_overflow` = 1 from the 3rd sample and still 1 in DONE. After `i_ack` it is 0.
- **Clear mid-block:** samples 4, 4, then `i_clear` together with `i_valid` = 1, `i_data` = 4 -> `o_acc` = 0, `o_count` = 0. The next 4 samples of 1 give `o_acc` = 4 and `o_valid` = 1.
- **Back-to-back blocks:** `i_ack` tied to 1 and `i_valid` held at 1 with `i_data` = 2 -> `o_valid` is high for exactly 1 cycle every 5 cycles, `o_acc` = 8 each time, and one sample is dropped per block during DONE.
